// File: rtl/sysctrl_gen.sv
// sysctrl_gen: MCU system-control endpoint.
// Decodes the byte-serial SPI bridge command stream and owns a generic table
// of configuration bytes addressed by ASCII id. It also provides masked,
// edge-latched interrupt pending bits and a timed core-reset generator.
module sysctrl_gen #(
  parameter logic [7:0]            CORE_ID      = 8'h02,
  parameter int                    NUM_VARS     = 16,
  parameter logic [7:0]            VAR_BASE     = 8'h41,
  parameter logic [NUM_VARS*8-1:0] VAR_DEFAULTS = '0,
  parameter int                    INT_W        = 8,
  parameter int                    RESET_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_in_strobe,
  input  logic                  data_in_start,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  output logic                  int_out_n,
  input  logic [INT_W-1:0]      int_in,
  input  logic [1:0]            buttons,
  output logic [1:0]            leds,
  output logic [23:0]           color,
  output logic [NUM_VARS*8-1:0] cfg,
  output logic [NUM_VARS-1:0]   cfg_strobe,
  output logic                  core_reset
);

  localparam logic [7:0] CMD_STATUS   = 8'd0;
  localparam logic [7:0] CMD_LEDS     = 8'd1;
  localparam logic [7:0] CMD_COLOR    = 8'd2;
  localparam logic [7:0] CMD_BUTTONS  = 8'd3;
  localparam logic [7:0] CMD_CFG_WR   = 8'd4;
  localparam logic [7:0] CMD_INT      = 8'd5;
  localparam logic [7:0] CMD_CFG_RD   = 8'd6;
  localparam logic [7:0] CMD_MASK     = 8'd7;
  localparam logic [7:0] CMD_CORE_RST = 8'd8;

  localparam logic [7:0] NUM_VARS_B = 8'(NUM_VARS);
  localparam logic [7:0] RST_LOAD   = 8'(RESET_CYCLES);

  // Bit-reverse a byte (ws2812 bytes arrive LSB-first from the MCU).
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

  // True when id addresses slot k; the id>=VAR_BASE test rejects wrapped offsets.
  function automatic logic slot_match(input logic [7:0] id, input int k);
    logic [7:0] off;
    off = id - VAR_BASE;
    return (id >= VAR_BASE) && (off == 8'(k));
  endfunction

  logic [3:0]            state_q, state_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [7:0]            id_q, id_d;
  logic [7:0]            data_out_q, data_out_d;
  logic [1:0]            leds_q, leds_d;
  logic [23:0]           color_q, color_d;
  logic [NUM_VARS*8-1:0] cfg_q, cfg_d;
  logic [NUM_VARS-1:0]   cfg_strobe_q, cfg_strobe_d;
  logic [INT_W-1:0]      pending_q, pending_d;
  logic [INT_W-1:0]      mask_q, mask_d;
  logic [INT_W-1:0]      int_prev_q;
  logic [7:0]            rst_cnt_q, rst_cnt_d;
  logic                  core_reset_q, core_reset_d;
  logic [INT_W-1:0]      ack_s;
  logic [7:0]            rd_val_s;

  // Command decode, payload execution and next-state computation.
  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    id_d         = id_q;
    data_out_d   = data_out_q;
    leds_d       = leds_q;
    color_d      = color_q;
    cfg_d        = cfg_q;
    cfg_strobe_d = '0;
    mask_d       = mask_q;
    ack_s        = '0;
    rd_val_s     = 8'h00;

    if (rst_cnt_q != 8'd0) begin
      rst_cnt_d = rst_cnt_q - 8'd1;
    end else begin
      rst_cnt_d = 8'd0;
    end

    for (int k = 0; k < NUM_VARS; k++) begin
      if (slot_match(data_in, k)) begin
        rd_val_s = cfg_q[8*k +: 8];
      end else begin
        rd_val_s = rd_val_s;
      end
    end

    if (data_in_strobe && data_in_start) begin
      state_d = 4'd1;
      cmd_d   = data_in;
    end else if (data_in_strobe && (state_q != 4'd0)) begin
      if (state_q == 4'd15) begin
        state_d = 4'd15;
      end else begin
        state_d = state_q + 4'd1;
      end
      case (cmd_q)
        CMD_STATUS: begin
          case (state_q)
            4'd1:    data_out_d = 8'h5c;
            4'd2:    data_out_d = 8'h42;
            4'd3:    data_out_d = CORE_ID;
            4'd4:    data_out_d = NUM_VARS_B;
            default: data_out_d = 8'h00;
          endcase
        end
        CMD_LEDS: begin
          if (state_q == 4'd1) begin
            leds_d = data_in[1:0];
          end else begin
            leds_d = leds_q;
          end
        end
        CMD_COLOR: begin
          case (state_q)
            4'd1:    color_d[15:8]  = rev8(data_in);
            4'd2:    color_d[7:0]   = rev8(data_in);
            4'd3:    color_d[23:16] = rev8(data_in);
            default: color_d        = color_q;
          endcase
        end
        CMD_BUTTONS: begin
          data_out_d = {6'b000000, buttons};
        end
        CMD_CFG_WR: begin
          if (state_q == 4'd1) begin
            id_d = data_in;
          end else if (state_q == 4'd2) begin
            for (int k = 0; k < NUM_VARS; k++) begin
              if (slot_match(id_q, k)) begin
                cfg_d[8*k +: 8] = data_in;
                cfg_strobe_d[k] = 1'b1;
              end else begin
                cfg_strobe_d[k] = 1'b0;
              end
            end
          end else begin
            id_d = id_q;
          end
        end
        CMD_INT: begin
          data_out_d = 8'(pending_q & mask_q);
          if (state_q == 4'd1) begin
            ack_s = data_in[INT_W-1:0];
          end else begin
            ack_s = '0;
          end
        end
        CMD_CFG_RD: begin
          if (state_q == 4'd1) begin
            data_out_d = rd_val_s;
          end else begin
            data_out_d = 8'h00;
          end
        end
        CMD_MASK: begin
          if (state_q == 4'd1) begin
            mask_d = data_in[INT_W-1:0];
          end else begin
            mask_d = mask_q;
          end
        end
        CMD_CORE_RST: begin
          if (state_q == 4'd1) begin
            rst_cnt_d = RST_LOAD;
          end else begin
            rst_cnt_d = rst_cnt_d;
          end
        end
        default: begin
          data_out_d = data_out_q;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    // A new edge wins over an acknowledge in the same cycle.
    pending_d    = (pending_q & ~ack_s) | (int_in & ~int_prev_q);
    core_reset_d = (rst_cnt_d != 8'd0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= 4'd0;
      cmd_q        <= 8'd0;
      id_q         <= 8'd0;
      data_out_q   <= 8'd0;
      leds_q       <= 2'd0;
      color_q      <= 24'd0;
      cfg_q        <= VAR_DEFAULTS;
      cfg_strobe_q <= '0;
      pending_q    <= '0;
      mask_q       <= {INT_W{1'b1}};
      int_prev_q   <= '0;
      rst_cnt_q    <= RST_LOAD;
      core_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      id_q         <= id_d;
      data_out_q   <= data_out_d;
      leds_q       <= leds_d;
      color_q      <= color_d;
      cfg_q        <= cfg_d;
      cfg_strobe_q <= cfg_strobe_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      int_prev_q   <= int_in;
      rst_cnt_q    <= rst_cnt_d;
      core_reset_q <= core_reset_d;
    end
  end

  assign data_out   = data_out_q;
  assign leds       = leds_q;
  assign color      = color_q;
  assign cfg        = cfg_q;
  assign cfg_strobe = cfg_strobe_q;
  assign core_reset = core_reset_q;
  assign int_out_n  = ~|(pending_q & mask_q);

endmodule
